// File: rtl/parking_pkg.sv
// Shared definitions for the parking occupancy tracker: lane FSM states,
// beam sensor patterns and a small popcount helper.
package parking_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_EN1  = 3'd1;
  localparam logic [ST_W-1:0] ST_EN2  = 3'd2;
  localparam logic [ST_W-1:0] ST_EN3  = 3'd3;
  localparam logic [ST_W-1:0] ST_EX1  = 3'd4;
  localparam logic [ST_W-1:0] ST_EX2  = 3'd5;
  localparam logic [ST_W-1:0] ST_EX3  = 3'd6;

  // Sensor pair encoded as {a, b}
  localparam logic [1:0] PAT_NONE = 2'b00;
  localparam logic [1:0] PAT_OUT  = 2'b10;
  localparam logic [1:0] PAT_BOTH = 2'b11;
  localparam logic [1:0] PAT_IN   = 2'b01;

  localparam int unsigned POP_IN_W  = 8;
  localparam int unsigned POP_OUT_W = 4;

  function automatic logic [POP_OUT_W-1:0] popcount(input logic [POP_IN_W-1:0] v);
    logic [POP_OUT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(POP_IN_W); i++) begin
      c = c + POP_OUT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/lane_direction_fsm.sv
// One lane: two-flop beam synchronizers, direction FSM and registered
// one-cycle enter/exit pulses on completed passages.
module lane_direction_fsm
  import parking_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic sens_a,
  input  logic sens_b,
  output logic car_enter,
  output logic car_exit
);

  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [ST_W-1:0] state;
  logic [ST_W-1:0] next_state;
  logic            enter_c;
  logic            exit_c;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {sens_a, sens_b};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      car_enter <= 1'b0;
      car_exit  <= 1'b0;
    end else begin
      state     <= next_state;
      car_enter <= enter_c;
      car_exit  <= exit_c;
    end
  end

  // Anything not listed (00 aborts, skipped steps) falls back to IDLE
  always_comb begin
    next_state = ST_IDLE;
    enter_c    = 1'b0;
    exit_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sync2 == PAT_OUT)     next_state = ST_EN1;
        else if (sync2 == PAT_IN) next_state = ST_EX1;
      end
      ST_EN1: begin
        if (sync2 == PAT_OUT)       next_state = ST_EN1;
        else if (sync2 == PAT_BOTH) next_state = ST_EN2;
      end
      ST_EN2: begin
        if (sync2 == PAT_BOTH)     next_state = ST_EN2;
        else if (sync2 == PAT_IN)  next_state = ST_EN3;
        else if (sync2 == PAT_OUT) next_state = ST_EN1;
      end
      ST_EN3: begin
        if (sync2 == PAT_IN)        next_state = ST_EN3;
        else if (sync2 == PAT_BOTH) next_state = ST_EN2;
        else if (sync2 == PAT_NONE) enter_c    = 1'b1;
      end
      ST_EX1: begin
        if (sync2 == PAT_IN)        next_state = ST_EX1;
        else if (sync2 == PAT_BOTH) next_state = ST_EX2;
      end
      ST_EX2: begin
        if (sync2 == PAT_BOTH)     next_state = ST_EX2;
        else if (sync2 == PAT_OUT) next_state = ST_EX3;
        else if (sync2 == PAT_IN)  next_state = ST_EX1;
      end
      ST_EX3: begin
        if (sync2 == PAT_OUT)       next_state = ST_EX3;
        else if (sync2 == PAT_BOTH) next_state = ST_EX2;
        else if (sync2 == PAT_NONE) exit_c     = 1'b1;
      end
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/parking_occupancy_tracker.sv
// Multi-lane parking occupancy tracker: per-lane direction FSMs feed one
// shared saturating occupancy counter with capacity flags and sticky errors.
module parking_occupancy_tracker
  import parking_pkg::*;
#(
  parameter int unsigned NUM_LANES   = 2,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned CAPACITY    = 15,
  parameter int unsigned ALMOST_FULL = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_LANES-1:0] sens_a,
  input  logic [NUM_LANES-1:0] sens_b,
  input  logic                 clear,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic [NUM_LANES-1:0] car_enter,
  output logic [NUM_LANES-1:0] car_exit,
  output logic                 err_ovf,
  output logic                 err_unf
);

  localparam int unsigned SUM_W = CNT_W + $clog2(NUM_LANES) + 2;

  logic [POP_OUT_W-1:0]    n_in;
  logic [POP_OUT_W-1:0]    n_out;
  logic signed [SUM_W-1:0] net_c;
  logic signed [SUM_W-1:0] sum_c;
  logic                    ovf_c;
  logic                    unf_c;
  logic [CNT_W-1:0]        count_next_c;

  for (genvar g = 0; g < int'(NUM_LANES); g++) begin : g_lane
    lane_direction_fsm u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .sens_a    (sens_a[g]),
      .sens_b    (sens_b[g]),
      .car_enter (car_enter[g]),
      .car_exit  (car_exit[g])
    );
  end

  // Entries and exits of the same cycle cancel before clamping
  always_comb begin
    n_in         = popcount(POP_IN_W'(car_enter));
    n_out        = popcount(POP_IN_W'(car_exit));
    net_c        = $signed(SUM_W'(n_in)) - $signed(SUM_W'(n_out));
    sum_c        = $signed(SUM_W'(count)) + net_c;
    ovf_c        = sum_c > $signed(SUM_W'(CAPACITY));
    unf_c        = sum_c < $signed(SUM_W'(0));
    count_next_c = CNT_W'(sum_c);
    if (ovf_c) begin
      count_next_c = CNT_W'(CAPACITY);
    end else if (unf_c) begin
      count_next_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count   <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      count <= count_next_c;
      if (ovf_c) err_ovf <= 1'b1;
      if (unf_c) err_unf <= 1'b1;
    end
  end

  assign full        = (count == CNT_W'(CAPACITY));
  assign empty       = (count == '0);
  assign almost_full = (count >= CNT_W'(ALMOST_FULL));

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// Self-checking bench: per-cycle comparison against a position-based lane
// model plus hand-computed checkpoints for each directed scenario.
module tb_parking_occupancy_tracker;

  localparam int NL  = 2;
  localparam int CW  = 4;
  localparam int CAP = 15;
  localparam int AF  = 12;

  logic          clk;
  logic          reset_n;
  logic [NL-1:0] sens_a;
  logic [NL-1:0] sens_b;
  logic          clear;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [NL-1:0] car_enter;
  logic [NL-1:0] car_exit;
  logic          err_ovf;
  logic          err_unf;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;
  int en_cnt[NL];
  int ex_cnt[NL];

  parking_occupancy_tracker #(
    .NUM_LANES(NL), .CNT_W(CW), .CAPACITY(CAP), .ALMOST_FULL(AF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sens_a(sens_a), .sens_b(sens_b),
    .clear(clear), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .car_enter(car_enter), .car_exit(car_exit),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a car is a position along its path (1..3), direction fixed by first beam
  int            m_dir[NL];
  int            m_pos[NL];
  logic [1:0]    m_s1[NL];
  logic [1:0]    m_s2[NL];
  int            m_count;
  bit            m_ovf;
  bit            m_unf;
  logic [NL-1:0] m_en;
  logic [NL-1:0] m_ex;

  function automatic int posof(input int dir, input logic [1:0] p);
    if (p == 2'b11) return 2;
    if (p == 2'b00) return 0;
    if (dir > 0) return (p == 2'b10) ? 1 : 3;
    return (p == 2'b01) ? 1 : 3;
  endfunction

  always @(posedge clk) begin
    logic [NL-1:0] nen, nex;
    int v, np;
    nen = '0;
    nex = '0;
    if (!reset_n) begin
      for (int i = 0; i < NL; i++) begin
        m_dir[i] = 0; m_pos[i] = 0; m_s1[i] = 2'b00; m_s2[i] = 2'b00;
      end
      m_count = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (clear) begin
        m_count = 0; m_ovf = 0; m_unf = 0;
      end else begin
        v = m_count + $countones(m_en) - $countones(m_ex);
        if (v > CAP) begin m_count = CAP; m_ovf = 1; end
        else if (v < 0) begin m_count = 0; m_unf = 1; end
        else m_count = v;
      end
      for (int i = 0; i < NL; i++) begin
        if (m_dir[i] == 0) begin
          if (m_s2[i] == 2'b10) begin m_dir[i] = 1; m_pos[i] = 1; end
          else if (m_s2[i] == 2'b01) begin m_dir[i] = -1; m_pos[i] = 1; end
        end else begin
          np = posof(m_dir[i], m_s2[i]);
          if (np == 0) begin
            if (m_pos[i] == 3) begin
              if (m_dir[i] > 0) nen[i] = 1'b1; else nex[i] = 1'b1;
            end
            m_dir[i] = 0;
          end else if (np == m_pos[i] + 1 || np == m_pos[i] - 1) begin
            m_pos[i] = np;
          end else if (np != m_pos[i]) begin
            m_dir[i] = 0;
          end
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = {sens_a[i], sens_b[i]};
      end
    end
    m_en = nen;
    m_ex = nex;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("count", 32'(count), 32'(m_count));
      chk("full", 32'(full), 32'(m_count == CAP));
      chk("empty", 32'(empty), 32'(m_count == 0));
      chk("almost_full", 32'(almost_full), 32'(m_count >= AF));
      chk("car_enter", 32'(car_enter), 32'(m_en));
      chk("car_exit", 32'(car_exit), 32'(m_ex));
      chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
      chk("err_unf", 32'(err_unf), 32'(m_unf));
      for (int i = 0; i < NL; i++) begin
        en_cnt[i] += int'(car_enter[i] === 1'b1);
        ex_cnt[i] += int'(car_exit[i] === 1'b1);
      end
    end
  end

  // kind: 0 idle, 1 entry, 2 exit, 3 back-out
  function automatic logic [1:0] pat(input int kind, input int stp);
    logic [1:0] s;
    s = 2'b00;
    if (stp >= 1 && stp <= 3) begin
      case (kind)
        1: s = (stp == 1) ? 2'b10 : (stp == 2) ? 2'b11 : 2'b01;
        2: s = (stp == 1) ? 2'b01 : (stp == 2) ? 2'b11 : 2'b10;
        3: s = (stp == 2) ? 2'b11 : (stp == 1 || stp == 3) ? 2'b10 : 2'b00;
        default: s = 2'b00;
      endcase
    end
    return s;
  endfunction

  task automatic set_pat(input int lane, input logic [1:0] p);
    sens_a[lane] = p[1];
    sens_b[lane] = p[0];
  endtask

  task automatic run_seq(input int k0, input int k1);
    for (int s = 0; s < 5; s++) begin
      set_pat(0, pat(k0, s));
      set_pat(1, pat(k1, s));
      repeat (4) @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int e0, x1;
    for (int i = 0; i < NL; i++) begin en_cnt[i] = 0; ex_cnt[i] = 0; end
    reset_n = 1'b0; clear = 1'b0; sens_a = '0; sens_b = '0;
    repeat (3) @(negedge clk);
    cmp_en = 1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Test 1: lane0 entry from count 3
    repeat (3) run_seq(1, 0);
    chk("t1_pre_count", 32'(count), 32'd3);
    e0 = en_cnt[0];
    run_seq(1, 0);
    chk("t1_count", 32'(count), 32'd4);
    chk("t1_pulses", 32'(en_cnt[0] - e0), 32'd1);

    // Test 2: lane1 exit on an empty lot
    do_clear();
    x1 = ex_cnt[1];
    run_seq(0, 2);
    chk("t2_count", 32'(count), 32'd0);
    chk("t2_err_unf", 32'(err_unf), 32'd1);
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_pulses", 32'(ex_cnt[1] - x1), 32'd1);

    // Test 3: back-out leaves count alone
    do_clear();
    chk("t3_unf_cleared", 32'(err_unf), 32'd0);
    run_seq(1, 1);
    e0 = en_cnt[0];
    run_seq(3, 0);
    chk("t3_count", 32'(count), 32'd2);
    chk("t3_pulses", 32'(en_cnt[0] - e0), 32'd0);

    // Test 4: saturation at capacity
    repeat (6) run_seq(1, 1);
    run_seq(1, 0);
    chk("t4_full_count", 32'(count), 32'd15);
    chk("t4_full", 32'(full), 32'd1);
    run_seq(1, 2);
    chk("t4_net_count", 32'(count), 32'd15);
    chk("t4_net_no_ovf", 32'(err_ovf), 32'd0);
    run_seq(1, 0);
    chk("t4_sat_count", 32'(count), 32'd15);
    chk("t4_err_ovf", 32'(err_ovf), 32'd1);
    do_clear();
    chk("t4_clr_count", 32'(count), 32'd0);
    chk("t4_clr_ovf", 32'(err_ovf), 32'd0);

    // Test 5: almost_full threshold and simultaneous entries to full
    repeat (5) run_seq(1, 1);
    run_seq(1, 0);
    chk("t5_count11", 32'(count), 32'd11);
    chk("t5_af_low", 32'(almost_full), 32'd0);
    run_seq(1, 0);
    chk("t5_count12", 32'(count), 32'd12);
    chk("t5_af_high", 32'(almost_full), 32'd1);
    run_seq(1, 0);
    run_seq(1, 1);
    chk("t5_count15", 32'(count), 32'd15);
    chk("t5_full", 32'(full), 32'd1);

    // Test 6: reset in the middle of an entry
    do_clear();
    repeat (3) run_seq(1, 1);
    run_seq(1, 0);
    chk("t6_count7", 32'(count), 32'd7);
    e0 = en_cnt[0];
    for (int s = 0; s < 3; s++) begin
      set_pat(0, pat(1, s));
      repeat (4) @(negedge clk);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("t6_rst_count", 32'(count), 32'd0);
    set_pat(0, 2'b01);
    repeat (4) @(negedge clk);
    set_pat(0, 2'b00);
    repeat (6) @(negedge clk);
    chk("t6_no_pulse", 32'(en_cnt[0] - e0), 32'd0);
    chk("t6_after_count", 32'(count), 32'd0);
    run_seq(1, 0);
    chk("t6_resume_count", 32'(count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
